// File: rtl/tpu_ram_arbiter.sv
// Two-master Wishbone arbiter sharing one RAM slave between the Caravel host (M0) and the TPU engine (M1).
// Round-robin on ties, one IDLE cycle between grants, per-grant ack watchdog with a sticky timeout flag.
module tpu_ram_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        caravel_wb_clk_i,
    input  logic        caravel_wb_rst_n_i,

    input  logic        m0_wb_cyc_i,
    input  logic        m0_wb_stb_i,
    input  logic        m0_wb_we_i,
    input  logic [3:0]  m0_wb_sel_i,
    input  logic [31:0] m0_wb_adr_i,
    input  logic [31:0] m0_wb_dat_i,
    output logic        m0_wb_ack_o,
    output logic        m0_wb_err_o,
    output logic [31:0] m0_wb_dat_o,

    input  logic        m1_wb_cyc_i,
    input  logic        m1_wb_stb_i,
    input  logic        m1_wb_we_i,
    input  logic [3:0]  m1_wb_sel_i,
    input  logic [31:0] m1_wb_adr_i,
    input  logic [31:0] m1_wb_dat_i,
    output logic        m1_wb_ack_o,
    output logic        m1_wb_err_o,
    output logic [31:0] m1_wb_dat_o,

    output logic        s_wb_cyc_o,
    output logic        s_wb_stb_o,
    output logic        s_wb_we_o,
    output logic [3:0]  s_wb_sel_o,
    output logic [31:0] s_wb_adr_o,
    output logic [31:0] s_wb_dat_o,
    input  logic        s_wb_ack_i,
    input  logic [31:0] s_wb_dat_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o,
    input  logic        timeout_clr_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_M0 = 2'd1,
        GRANT_M1 = 2'd2
    } state_e;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        last_q, last_d;      // 1 = M1 was granted last
    logic [7:0]  wdog_q, wdog_d;
    logic        timeout_q, timeout_d;

    logic req0, req1, granted, own_cyc, wd_hit;

    assign req0    = m0_wb_cyc_i & m0_wb_stb_i;
    assign req1    = m1_wb_cyc_i & m1_wb_stb_i;
    assign granted = (state_q != IDLE);
    assign own_cyc = (state_q == GRANT_M0) ? m0_wb_cyc_i : m1_wb_cyc_i;
    // Ack in the last watchdog cycle takes priority over the timeout.
    assign wd_hit  = granted & own_cyc & ~s_wb_ack_i & (wdog_q == WD_LAST);

    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
        if (!caravel_wb_rst_n_i) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            wdog_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        if (timeout_clr_i) timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                wdog_d = 8'd0;
                if (req0 && req1)  state_d = last_q ? GRANT_M0 : GRANT_M1;
                else if (req0)     state_d = GRANT_M0;
                else if (req1)     state_d = GRANT_M1;
            end
            GRANT_M0, GRANT_M1: begin
                if (s_wb_ack_i || !own_cyc || wd_hit) begin
                    state_d = IDLE;
                    last_d  = (state_q == GRANT_M1);
                    if (wd_hit) timeout_d = 1'b1;
                end else begin
                    wdog_d = (wdog_q == WD_LAST) ? 8'd0 : wdog_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_wb_cyc_o  = 1'b0;
        s_wb_stb_o  = 1'b0;
        s_wb_we_o   = 1'b0;
        s_wb_sel_o  = 4'h0;
        s_wb_adr_o  = 32'h0;
        s_wb_dat_o  = 32'h0;
        m0_wb_ack_o = 1'b0;
        m0_wb_err_o = 1'b0;
        m0_wb_dat_o = 32'h0;
        m1_wb_ack_o = 1'b0;
        m1_wb_err_o = 1'b0;
        m1_wb_dat_o = 32'h0;
        grant_o     = 2'b00;
        timeout_o   = timeout_q;
        unique case (state_q)
            GRANT_M0: begin
                grant_o     = 2'b01;
                s_wb_cyc_o  = m0_wb_cyc_i & ~wd_hit;
                s_wb_stb_o  = m0_wb_stb_i & ~wd_hit;
                s_wb_we_o   = m0_wb_we_i;
                s_wb_sel_o  = m0_wb_sel_i;
                s_wb_adr_o  = m0_wb_adr_i;
                s_wb_dat_o  = m0_wb_dat_i;
                m0_wb_ack_o = s_wb_ack_i;
                m0_wb_err_o = wd_hit;
                m0_wb_dat_o = s_wb_dat_i;
            end
            GRANT_M1: begin
                grant_o     = 2'b10;
                s_wb_cyc_o  = m1_wb_cyc_i & ~wd_hit;
                s_wb_stb_o  = m1_wb_stb_i & ~wd_hit;
                s_wb_we_o   = m1_wb_we_i;
                s_wb_sel_o  = m1_wb_sel_i;
                s_wb_adr_o  = m1_wb_adr_i;
                s_wb_dat_o  = m1_wb_dat_i;
                m1_wb_ack_o = s_wb_ack_i;
                m1_wb_err_o = wd_hit;
                m1_wb_dat_o = s_wb_dat_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tpu_ram_arbiter.sv
// Directed bench for tpu_ram_arbiter: inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
module tb_tpu_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [3:0]  m0_sel = 0;
    logic [31:0] m0_adr = 0, m0_dat_w = 0;
    logic        m0_ack, m0_err;
    logic [31:0] m0_dat_r;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [3:0]  m1_sel = 0;
    logic [31:0] m1_adr = 0, m1_dat_w = 0;
    logic        m1_ack, m1_err;
    logic [31:0] m1_dat_r;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_dat_w;
    logic        s_ack = 0;
    logic [31:0] s_dat_r = 0;
    logic [1:0]  grant;
    logic        tmo;
    logic        tmo_clr = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tpu_ram_arbiter #(.TIMEOUT(16)) dut (
        .caravel_wb_clk_i   (clk),
        .caravel_wb_rst_n_i (rst_n),
        .m0_wb_cyc_i (m0_cyc), .m0_wb_stb_i (m0_stb), .m0_wb_we_i (m0_we),
        .m0_wb_sel_i (m0_sel), .m0_wb_adr_i (m0_adr), .m0_wb_dat_i (m0_dat_w),
        .m0_wb_ack_o (m0_ack), .m0_wb_err_o (m0_err), .m0_wb_dat_o (m0_dat_r),
        .m1_wb_cyc_i (m1_cyc), .m1_wb_stb_i (m1_stb), .m1_wb_we_i (m1_we),
        .m1_wb_sel_i (m1_sel), .m1_wb_adr_i (m1_adr), .m1_wb_dat_i (m1_dat_w),
        .m1_wb_ack_o (m1_ack), .m1_wb_err_o (m1_err), .m1_wb_dat_o (m1_dat_r),
        .s_wb_cyc_o (s_cyc), .s_wb_stb_o (s_stb), .s_wb_we_o (s_we),
        .s_wb_sel_o (s_sel), .s_wb_adr_o (s_adr), .s_wb_dat_o (s_dat_w),
        .s_wb_ack_i (s_ack), .s_wb_dat_i (s_dat_r),
        .grant_o (grant), .timeout_o (tmo), .timeout_clr_i (tmo_clr)
    );

    task automatic set_m0(input logic c, input logic s, input logic w, input logic [3:0] sl,
                          input logic [31:0] a, input logic [31:0] d);
        m0_cyc = c; m0_stb = s; m0_we = w; m0_sel = sl; m0_adr = a; m0_dat_w = d;
    endtask

    task automatic set_m1(input logic c, input logic s, input logic w, input logic [3:0] sl,
                          input logic [31:0] a, input logic [31:0] d);
        m1_cyc = c; m1_stb = s; m1_we = w; m1_sel = sl; m1_adr = a; m1_dat_w = d;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b exp=00", grant); end
        total++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin bad++; $display("FAIL rst_s_cyc got=%b%b exp=00", s_cyc, s_stb); end
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", tmo); end
        total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_err !== 1'b0 || m1_err !== 1'b0)
            begin bad++; $display("FAIL rst_m_ack_err got=%b%b%b%b exp=0000", m0_ack, m1_ack, m0_err, m1_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write;
        @(posedge clk); #1;
        set_m0(1, 1, 1, 4'hF, 32'h3000_0010, 32'hA5A5_A5A5);
        @(negedge clk);
        total++; if (grant !== 2'b00 || s_stb !== 1'b0) begin bad++; $display("FAIL wr_pre grant=%b stb=%b exp=00/0", grant, s_stb); end
        @(posedge clk); @(negedge clk);
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL wr_grant got=%b exp=01", grant); end
        total++; if (s_stb !== 1'b1 || s_cyc !== 1'b1 || s_we !== 1'b1) begin bad++; $display("FAIL wr_s_ctl got=%b%b%b exp=111", s_cyc, s_stb, s_we); end
        total++; if (s_adr !== 32'h3000_0010 || s_dat_w !== 32'hA5A5_A5A5 || s_sel !== 4'hF)
            begin bad++; $display("FAIL wr_s_bus adr=%h dat=%h sel=%h exp=30000010/a5a5a5a5/f", s_adr, s_dat_w, s_sel); end
        total++; if (m0_ack !== 1'b0) begin bad++; $display("FAIL wr_early_ack got=%b exp=0", m0_ack); end
        @(posedge clk); #1;
        s_ack = 1'b1;
        @(negedge clk);
        total++; if (m0_ack !== 1'b1 || grant !== 2'b01) begin bad++; $display("FAIL wr_ack ack=%b grant=%b exp=1/01", m0_ack, grant); end
        @(posedge clk); #1;
        s_ack = 1'b0;
        set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        total++; if (grant !== 2'b00 || s_cyc !== 1'b0) begin bad++; $display("FAIL wr_release grant=%b cyc=%b exp=00/0", grant, s_cyc); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_g [3];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        apply_reset();
        @(posedge clk); #1;
        set_m0(1, 1, 0, 4'hF, 32'h3000_0100, 32'h0);
        set_m1(1, 1, 0, 4'hF, 32'h3000_0200, 32'h0);
        for (int g = 0; g < 3; g++) begin
            @(posedge clk); #1;
            s_ack = 1'b1;
            @(negedge clk);
            total++; if (grant !== exp_g[g]) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", g, grant, exp_g[g]); end
            total++; if ({m1_ack, m0_ack} !== exp_g[g]) begin bad++; $display("FAIL rr_ack%0d got=%b exp=%b", g, {m1_ack, m0_ack}, exp_g[g]); end
            @(posedge clk); #1;
            s_ack = 1'b0;
            if (g == 2) begin
                set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
                set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
            end
            @(negedge clk);
            total++; if (grant !== 2'b00) begin bad++; $display("FAIL rr_idle%0d got=%b exp=00", g, grant); end
        end
    endtask

    task automatic test_read;
        @(posedge clk); #1;
        s_dat_r = 32'h1234_5678;
        s_ack   = 1'b1;
        @(negedge clk);
        total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_dat_r !== 32'h0 || m1_dat_r !== 32'h0)
            begin bad++; $display("FAIL idle_ack_leak ack=%b%b d0=%h d1=%h exp=00/0/0", m1_ack, m0_ack, m0_dat_r, m1_dat_r); end
        s_ack = 1'b0;
        @(posedge clk); #1;
        set_m1(1, 1, 0, 4'hF, 32'h3000_0020, 32'h0);
        @(posedge clk); #1;
        s_ack = 1'b1;
        @(negedge clk);
        total++; if (m1_ack !== 1'b1 || m1_dat_r !== 32'h1234_5678) begin bad++; $display("FAIL rd_m1 ack=%b dat=%h exp=1/12345678", m1_ack, m1_dat_r); end
        total++; if (m0_dat_r !== 32'h0 || m0_ack !== 1'b0) begin bad++; $display("FAIL rd_m0_quiet ack=%b dat=%h exp=0/0", m0_ack, m0_dat_r); end
        total++; if (s_adr !== 32'h3000_0020 || s_we !== 1'b0) begin bad++; $display("FAIL rd_s_bus adr=%h we=%b exp=30000020/0", s_adr, s_we); end
        @(posedge clk); #1;
        s_ack = 1'b0;
        s_dat_r = 32'h0;
        set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        total++; if (grant !== 2'b00 || m1_dat_r !== 32'h0) begin bad++; $display("FAIL rd_release grant=%b dat=%h exp=00/0", grant, m1_dat_r); end
    endtask

    task automatic test_timeout;
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk); #1;
            set_m0(1, 1, 1, 4'hF, 32'h3000_0040, 32'hDEAD_BEEF);
            for (int k = 1; k <= 16; k++) begin
                @(posedge clk); #1;
                if (k == 16 && pass == 1) tmo_clr = 1'b1;
                @(negedge clk);
                if (k < 16) begin
                    total++; if (m0_err !== 1'b0 || s_cyc !== 1'b1) begin bad++; $display("FAIL to_early p%0d k%0d err=%b cyc=%b exp=0/1", pass, k, m0_err, s_cyc); end
                end else begin
                    total++; if (m0_err !== 1'b1 || m0_ack !== 1'b0) begin bad++; $display("FAIL to_err p%0d err=%b ack=%b exp=1/0", pass, m0_err, m0_ack); end
                    total++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin bad++; $display("FAIL to_s_force p%0d cyc=%b stb=%b exp=0/0", pass, s_cyc, s_stb); end
                    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL to_flag_early p%0d got=%b exp=0", pass, tmo); end
                end
            end
            @(posedge clk); #1;
            tmo_clr = 1'b0;
            set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            total++; if (tmo !== 1'b1 || grant !== 2'b00 || m0_err !== 1'b0)
                begin bad++; $display("FAIL to_set p%0d tmo=%b grant=%b err=%b exp=1/00/0", pass, tmo, grant, m0_err); end
            repeat (3) @(posedge clk);
            @(negedge clk);
            total++; if (tmo !== 1'b1) begin bad++; $display("FAIL to_sticky p%0d got=%b exp=1", pass, tmo); end
            @(posedge clk); #1;
            tmo_clr = 1'b1;
            @(posedge clk); #1;
            tmo_clr = 1'b0;
            @(negedge clk);
            total++; if (tmo !== 1'b0) begin bad++; $display("FAIL to_clear p%0d got=%b exp=0", pass, tmo); end
        end
    endtask

    task automatic test_ack_at_limit;
        @(posedge clk); #1;
        set_m0(1, 1, 0, 4'hF, 32'h3000_0080, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 16) s_ack = 1'b1;
            @(negedge clk);
        end
        total++; if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin bad++; $display("FAIL lim_ack ack=%b err=%b exp=1/0", m0_ack, m0_err); end
        total++; if (s_cyc !== 1'b1) begin bad++; $display("FAIL lim_cyc got=%b exp=1", s_cyc); end
        @(posedge clk); #1;
        s_ack = 1'b0;
        set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        total++; if (tmo !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL lim_after tmo=%b grant=%b exp=0/00", tmo, grant); end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        set_m1(1, 1, 1, 4'h3, 32'h3000_0400, 32'h5555_AAAA);
        @(posedge clk); @(negedge clk);
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL rm_grant got=%b exp=10", grant); end
        #2;
        s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        total++; if (s_cyc !== 1'b0 || s_stb !== 1'b0 || grant !== 2'b00)
            begin bad++; $display("FAIL rm_async cyc=%b stb=%b grant=%b exp=0/0/00", s_cyc, s_stb, grant); end
        total++; if (m1_ack !== 1'b0 || m1_err !== 1'b0 || m1_dat_r !== 32'h0)
            begin bad++; $display("FAIL rm_no_ack ack=%b err=%b dat=%h exp=0/0/0", m1_ack, m1_err, m1_dat_r); end
        @(posedge clk); #1;
        s_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL rm_regrant got=%b exp=10", grant); end
        @(posedge clk); #1;
        set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); @(negedge clk);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rm_drop got=%b exp=00", grant); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_read();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tpu_ram_arbiter.md
TPU_RAM_ARBITER -- requirements
Module: tpu_ram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles a granted transfer may wait for slave ack (legal 2..255).
REQ-002 caravel_wb_clk_i  input  1  single clock; all state on rising edge.
REQ-003 caravel_wb_rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i  input  1 each  host (Caravel) master Wishbone controls.
REQ-005 m0_wb_sel_i  input  4;  m0_wb_adr_i, m0_wb_dat_i  input  32 each  host master byte select, address, write data.
REQ-006 m0_wb_ack_o, m0_wb_err_o  output  1 each;  m0_wb_dat_o  output  32  host master ack, timeout error, read data.
REQ-007 m1_wb_* (same names, directions, widths as REQ-004..006)  TPU engine master port.
REQ-008 s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  output  1 each;  s_wb_sel_o  output  4;  s_wb_adr_o, s_wb_dat_o  output  32  shared RAM slave port.
REQ-009 s_wb_ack_i  input  1;  s_wb_dat_i  input  32  RAM ack and read data.
REQ-010 grant_o  output  2  one-hot current owner (bit0 = M0, bit1 = M1); 00 when idle.
REQ-011 timeout_o  output  1  sticky timeout flag;  timeout_clr_i  input  1  synchronous clear of timeout_o.

Function
REQ-012 FSM states IDLE, GRANT_M0, GRANT_M1; a master requests when cyc_i & stb_i.
REQ-013 IDLE, exactly one request: move to that master's GRANT state next edge.
REQ-014 IDLE, both requesting: grant the master not granted last (round-robin); last_grant resets to M1, so M0 wins the first tie.
REQ-015 IDLE, no request: stay in IDLE; s_wb_* outputs all 0.
REQ-016 In GRANT_Mx, s_wb_cyc/stb/we/sel/adr/dat_o combinationally follow master x inputs; s_wb_ack_i drives mx_wb_ack_o and s_wb_dat_i drives mx_wb_dat_o combinationally.
REQ-017 The non-granted master sees ack_o = 0, err_o = 0, dat_o = 0 (stalled) for as long as it requests.
REQ-018 Latency: request first sampled at edge N gives slave stb asserted in cycle N+1; ack passes to the master in the same cycle it arrives.
REQ-019 GRANT_Mx exits to IDLE on the edge where s_wb_ack_i = 1 or master x drops cyc_i; last_grant updates to x; a new grant always needs one IDLE cycle in between.
REQ-020 Watchdog counter: cleared on entry to GRANT state, increments each granted cycle without ack; at TIMEOUT it wraps to 0.
REQ-021 On counter == TIMEOUT-1 with no ack: mx_wb_err_o = 1 for that one cycle, ack_o stays 0, s_wb_cyc/stb_o forced to 0 that cycle, timeout_o set, FSM -> IDLE.
REQ-022 Ack and timeout in the same cycle: the ack wins; no err, timeout_o unchanged.
REQ-023 timeout_o is sticky; timeout_clr_i clears it next edge; a set and a clear in the same cycle leave timeout_o = 1.
REQ-024 A master that drops cyc_i while not granted loses its pending request; no state is kept for it.
REQ-025 An ack arriving in IDLE is ignored and not routed to either master.

Reset
REQ-026 Reset asserted: FSM = IDLE, last_grant = M1, watchdog = 0, timeout_o = 0, grant_o = 00 immediately without waiting for a clock edge.
REQ-027 While in reset, all s_wb_* outputs and all m*_wb_ack/err/dat_o are 0.
REQ-028 Reset mid-transfer aborts the transfer with no ack or err to either master.
REQ-029 After reset deasserts, the first edge evaluates arbitration normally.

Verification
REQ-030 M0 alone writes 0xA5A5A5A5 to 0x30000010, RAM acks 1 cycle after stb -> s_wb_stb_o in cycle N+1, m0_wb_ack_o in the ack cycle, grant_o 01 then 00.
REQ-031 M0 and M1 request in the same cycle after reset, then both re-request -> grant order M0, M1, M0, with one IDLE cycle between grants.
REQ-032 M1 reads 0x30000020 while RAM returns 0x12345678 -> m1_wb_dat_o = 0x12345678 with ack; m0_wb_dat_o stays 0 throughout.
REQ-033 TIMEOUT=16, RAM never acks M0 -> m0_wb_err_o pulses in the 16th granted cycle, timeout_o = 1 and stays 1 until timeout_clr_i is pulsed.
REQ-034 Ack arrives in the 16th granted cycle -> ack delivered, no err, timeout_o stays 0.
REQ-035 caravel_wb_rst_n_i pulled low mid-grant -> s_wb_cyc_o and grant_o drop asynchronously; the aborted master gets no ack.
